pe_multi_filter: RTL and testbench

PE_MULTI_FILTER -- requirements
Module: pe_multi_filter

---
 rtl/pe_pkg.sv | 24 ++
 rtl/psum_fifo.sv | 60 ++++++
 rtl/pe_multi_filter.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pe_multi_filter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the multi-filter processing element.
package pe_pkg;

   // Controller states of the processing element
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_FILT = 3'd1,
      FILL      = 3'd2,
      MAC       = 3'd3,
      FLUSH     = 3'd4,
      ROW_END   = 3'd5
   } state_t;

   // Largest positive value representable in a signed field of width w
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Most negative value representable in a signed field of width w
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// First-word fall-through FIFO holding finished partial sums.
// A push is accepted while full as long as a pop happens in the same cycle.
module psum_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           clear,
   input  logic                           wr_en,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           rd_en,
   output logic [WIDTH-1:0]               rd_data,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   // Storage array, written on every accepted push
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointer and fill-level bookkeeping
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= next_ptr(wr_ptr);
         if (do_rd) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/pe_multi_filter.sv
// Row-stationary style PE: buffers an ifmap row in a circular window,
// applies NUM_FILT filters to every window position and streams out
// saturated partial sums through a small FWFT FIFO.
module pe_multi_filter
   import pe_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FILT_W     = 8,
   parameter int ACC_W      = 24,
   parameter int NUM_FILT   = 2,
   parameter int MAX_TAPS   = 12,
   parameter int WIN_DEPTH  = 16,
   parameter int PSUM_DEPTH = 8,
   parameter int STRIDE_W   = 3
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            cfg_ld,
   input  logic [STRIDE_W-1:0]             stride,
   input  logic [$clog2(MAX_TAPS+1)-1:0]   filter_size,
   input  logic                            clear,
   input  logic [FILT_W-1:0]               filt_in,
   input  logic                            filt_valid,
   output logic                            filt_ready,
   input  logic [DATA_W-1:0]               if_in,
   input  logic                            if_last,
   input  logic                            if_valid,
   output logic                            if_ready,
   output logic [ACC_W-1:0]                psum_out,
   output logic                            psum_valid,
   input  logic                            psum_ready,
   output logic                            busy,
   output logic                            row_done,
   output logic                            cfg_err
);

   localparam int FS_W    = $clog2(MAX_TAPS + 1);
   localparam int PTR_W   = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
   localparam int OCC_W   = $clog2(WIN_DEPTH + 1);
   localparam int FIDX_W  = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
   localparam int TAP_W   = (NUM_FILT * MAX_TAPS > 1) ? $clog2(NUM_FILT * MAX_TAPS) : 1;
   localparam int PROD_W  = DATA_W + FILT_W;
   localparam int CNT_W   = $clog2(PSUM_DEPTH + 1);
   localparam int IF_W    = CNT_W + 1;
   localparam longint ACC_MAX = sat_max(ACC_W);
   localparam longint ACC_MIN = sat_min(ACC_W);

   state_t                     state;
   logic [STRIDE_W-1:0]        stride_q;
   logic [FS_W-1:0]            fsize_q;
   logic signed [FILT_W-1:0]   filt_mem [NUM_FILT*MAX_TAPS];
   logic signed [DATA_W-1:0]   win_mem  [WIN_DEPTH];
   logic [FIDX_W-1:0]          ld_f;
   logic [FS_W-1:0]            ld_k;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           base;
   logic [OCC_W-1:0]           occ;
   logic [OCC_W-1:0]           occ_dec;
   logic                       last_seen;
   logic [FIDX_W-1:0]          iss_f;
   logic [FS_W-1:0]            iss_k;

   logic                       s1_valid, s1_first, s1_last;
   logic signed [DATA_W-1:0]   s1_data;
   logic signed [FILT_W-1:0]   s1_tap;
   logic                       p_valid, p_first, p_last;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_sat;
   longint                     acc_sum;
   logic [IF_W-1:0]            inflight;

   logic                       filt_fire, if_fire;
   logic                       cfg_bad;
   logic                       issue_ok, issue_fire, last_tap;
   logic                       psum_start, psum_push;
   logic [PTR_W-1:0]           rd_addr;
   logic [TAP_W-1:0]           tap_addr, ld_addr;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_count;

   function automatic logic [PTR_W-1:0] wrap_ptr(input int p);
      return PTR_W'(p % WIN_DEPTH);
   endfunction

   assign filt_ready = (state == LOAD_FILT);
   assign if_ready   = (state == FILL) && (occ < OCC_W'(WIN_DEPTH)) && !last_seen;
   assign filt_fire  = filt_valid && filt_ready;
   assign if_fire    = if_valid && if_ready;
   assign cfg_bad    = (filter_size == '0) || (int'(filter_size) > MAX_TAPS);

   // A new psum only starts when the FIFO has a slot reserved for it, so
   // psums already in the pipeline can always land without loss.
   assign issue_ok   = (iss_k != '0) || ((int'(fifo_count) + int'(inflight)) < PSUM_DEPTH);
   assign issue_fire = (state == MAC) && issue_ok;
   assign last_tap   = (iss_f == FIDX_W'(NUM_FILT - 1)) && (iss_k == fsize_q - FS_W'(1));
   assign psum_start = issue_fire && (iss_k == '0);
   assign psum_push  = p_valid && p_last;
   assign rd_addr    = wrap_ptr(int'(base) + int'(iss_k));
   assign tap_addr   = TAP_W'(int'(iss_f) * MAX_TAPS + int'(iss_k));
   assign ld_addr    = TAP_W'(int'(ld_f) * MAX_TAPS + int'(ld_k));
   assign occ_dec    = (OCC_W'(stride_q) < occ) ? OCC_W'(stride_q) : occ;
   assign busy       = (state != IDLE) || !fifo_empty;
   assign psum_valid = !fifo_empty;

   // Saturating accumulate; the first tap of each psum restarts from zero
   always_comb begin
      acc_sum = (p_first ? longint'(0) : longint'(acc)) + longint'(prod);
      acc_sat = ACC_W'(acc_sum);
      if (acc_sum > ACC_MAX) acc_sat = ACC_W'(ACC_MAX);
      if (acc_sum < ACC_MIN) acc_sat = ACC_W'(ACC_MIN);
   end

   // Filter and window storage; contents are only meaningful once loaded
   always_ff @(posedge clk) begin
      if (filt_fire) filt_mem[ld_addr] <= $signed(filt_in);
      if (if_fire)   win_mem[wr_ptr]   <= $signed(if_in);
   end

   // Controller: configuration, filter load, window bookkeeping and tap issue
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         stride_q  <= STRIDE_W'(1);
         fsize_q   <= FS_W'(1);
         ld_f      <= '0;
         ld_k      <= '0;
         wr_ptr    <= '0;
         base      <= '0;
         occ       <= '0;
         last_seen <= 1'b0;
         iss_f     <= '0;
         iss_k     <= '0;
         row_done  <= 1'b0;
         cfg_err   <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         ld_f      <= '0;
         ld_k      <= '0;
         wr_ptr    <= '0;
         base      <= '0;
         occ       <= '0;
         last_seen <= 1'b0;
         iss_f     <= '0;
         iss_k     <= '0;
         row_done  <= 1'b0;
      end else begin
         row_done <= 1'b0;
         occ <= OCC_W'(int'(occ) + (if_fire ? 1 : 0) - ((issue_fire && last_tap) ? int'(occ_dec) : 0));
         if (if_fire) begin
            wr_ptr <= wrap_ptr(int'(wr_ptr) + 1);
            if (if_last) last_seen <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (cfg_ld) begin
                  cfg_err <= cfg_bad;
                  if (!cfg_bad) begin
                     stride_q <= (stride == '0) ? STRIDE_W'(1) : stride;
                     fsize_q  <= filter_size;
                     ld_f     <= '0;
                     ld_k     <= '0;
                     state    <= LOAD_FILT;
                  end
               end
            end
            LOAD_FILT: begin
               if (filt_fire) begin
                  if (ld_k == fsize_q - FS_W'(1)) begin
                     ld_k <= '0;
                     if (ld_f == FIDX_W'(NUM_FILT - 1)) begin
                        ld_f  <= '0;
                        state <= FILL;
                     end else begin
                        ld_f <= ld_f + FIDX_W'(1);
                     end
                  end else begin
                     ld_k <= ld_k + FS_W'(1);
                  end
               end
            end
            FILL: begin
               if (occ >= OCC_W'(fsize_q)) begin
                  iss_f <= '0;
                  iss_k <= '0;
                  state <= MAC;
               end else if (last_seen && (inflight == '0)) begin
                  state <= FLUSH;
               end
            end
            MAC: begin
               if (issue_fire) begin
                  if (last_tap) begin
                     base  <= wrap_ptr(int'(base) + int'(stride_q));
                     state <= FILL;
                  end else if (iss_k == fsize_q - FS_W'(1)) begin
                     iss_k <= '0;
                     iss_f <= iss_f + FIDX_W'(1);
                  end else begin
                     iss_k <= iss_k + FS_W'(1);
                  end
               end
            end
            FLUSH: begin
               occ       <= '0;
               base      <= wr_ptr;
               last_seen <= 1'b0;
               row_done  <= 1'b1;
               state     <= ROW_END;
            end
            ROW_END: begin
               state <= FILL;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-stage MAC pipeline: registered operands, then registered product
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_data  <= '0;
         s1_tap   <= '0;
         p_valid  <= 1'b0;
         p_first  <= 1'b0;
         p_last   <= 1'b0;
         prod     <= '0;
         acc      <= '0;
         inflight <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_data  <= '0;
         s1_tap   <= '0;
         p_valid  <= 1'b0;
         p_first  <= 1'b0;
         p_last   <= 1'b0;
         prod     <= '0;
         acc      <= '0;
         inflight <= '0;
      end else begin
         s1_valid <= issue_fire;
         if (issue_fire) begin
            s1_data  <= win_mem[rd_addr];
            s1_tap   <= filt_mem[tap_addr];
            s1_first <= (iss_k == '0);
            s1_last  <= (iss_k == fsize_q - FS_W'(1));
         end
         p_valid <= s1_valid;
         if (s1_valid) begin
            prod    <= PROD_W'(s1_data) * PROD_W'(s1_tap);
            p_first <= s1_first;
            p_last  <= s1_last;
         end
         if (p_valid) acc <= acc_sat;
         inflight <= inflight + IF_W'(psum_start) - IF_W'(psum_push);
      end
   end

   psum_fifo #(
      .WIDTH (ACC_W),
      .DEPTH (PSUM_DEPTH)
   ) u_psum_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (clear),
      .wr_en   (psum_push),
      .wr_data (acc_sat),
      .rd_en   (psum_ready),
      .rd_data (psum_out),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_pe_multi_filter.sv
// Directed bench for pe_multi_filter with hand-computed psum sequences.
module tb_pe_multi_filter;

   localparam int DATA_W     = 16;
   localparam int FILT_W     = 8;
   localparam int ACC_W      = 24;
   localparam int NUM_FILT   = 2;
   localparam int MAX_TAPS   = 12;
   localparam int WIN_DEPTH  = 16;
   localparam int PSUM_DEPTH = 8;
   localparam int STRIDE_W   = 3;
   localparam int FS_W       = $clog2(MAX_TAPS + 1);

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                cfg_ld = 1'b0;
   logic                clear = 1'b0;
   logic [STRIDE_W-1:0] stride = '0;
   logic [FS_W-1:0]     filter_size = '0;
   logic [FILT_W-1:0]   filt_in = '0;
   logic                filt_valid = 1'b0;
   logic [DATA_W-1:0]   if_in = '0;
   logic                if_last = 1'b0;
   logic                if_valid = 1'b0;
   logic                psum_ready = 1'b0;
   logic                filt_ready, if_ready, psum_valid, busy, row_done, cfg_err;
   logic [ACC_W-1:0]    psum_out;

   int total = 0;
   int bad   = 0;
   int got[$];
   int row_cnt = 0;
   int rb;
   bit feed_done;

   int taps_a[6]   = '{1, 2, 3, -1, 0, 1};
   int taps_sat[6] = '{127, 127, 127, -128, -128, -128};
   int row_a[5]    = '{1, 2, 3, 4, 5};
   int row_sat[5]  = '{32767, 32767, 32767, 0, 0};
   int exp_basic[12] = '{14, 2, 20, 2, 26, 2, 0, 0, 0, 0, 0, 0};
   int exp_stride[12] = '{14, 2, 26, 2, 0, 0, 0, 0, 0, 0, 0, 0};
   int exp_bp[12]  = '{14, 2, 20, 2, 26, 2, 14, 2, 20, 2, 26, 2};
   int exp_sat[12] = '{8388607, -8388608, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   pe_multi_filter #(
      .DATA_W (DATA_W), .FILT_W (FILT_W), .ACC_W (ACC_W), .NUM_FILT (NUM_FILT),
      .MAX_TAPS (MAX_TAPS), .WIN_DEPTH (WIN_DEPTH), .PSUM_DEPTH (PSUM_DEPTH),
      .STRIDE_W (STRIDE_W)
   ) dut (
      .clk (clk), .rstn (rstn), .cfg_ld (cfg_ld), .stride (stride),
      .filter_size (filter_size), .clear (clear),
      .filt_in (filt_in), .filt_valid (filt_valid), .filt_ready (filt_ready),
      .if_in (if_in), .if_last (if_last), .if_valid (if_valid), .if_ready (if_ready),
      .psum_out (psum_out), .psum_valid (psum_valid), .psum_ready (psum_ready),
      .busy (busy), .row_done (row_done), .cfg_err (cfg_err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Record psum transfers and row_done pulses mid-cycle
   always @(negedge clk) begin
      if (rstn && !clear && psum_valid && psum_ready) got.push_back(int'($signed(psum_out)));
      if (rstn && row_done) row_cnt++;
   end

   // Safety net so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int st, input int fs);
      stride      = STRIDE_W'(st);
      filter_size = FS_W'(fs);
      cfg_ld      = 1'b1;
      tick();
      cfg_ld      = 1'b0;
   endtask

   task automatic doClear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      got.delete();
   endtask

   task automatic loadTap(input int v);
      int t = 0;
      filt_in    = FILT_W'(v);
      filt_valid = 1'b1;
      @(negedge clk);
      while (!filt_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!filt_ready) checkOutput("filt_handshake_timeout", filt_ready, 1);
      tick();
      filt_valid = 1'b0;
   endtask

   task automatic loadFilters(input int taps[6]);
      for (int i = 0; i < 6; i++) loadTap(taps[i]);
   endtask

   task automatic applyStimulus(input int v, input bit last);
      int t = 0;
      if_in    = DATA_W'(v);
      if_last  = last;
      if_valid = 1'b1;
      @(negedge clk);
      while (!if_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!if_ready) checkOutput("if_handshake_timeout", if_ready, 1);
      tick();
      if_valid = 1'b0;
      if_last  = 1'b0;
   endtask

   task automatic feedRow(input int vals[5], input int n);
      for (int i = 0; i < n; i++) applyStimulus(vals[i], i == n - 1);
   endtask

   task automatic waitRows(input int target);
      int t = 0;
      while (row_cnt < target && t < 3000) begin
         tick();
         t++;
      end
      if (row_cnt < target) checkOutput("row_done_timeout", row_cnt, target);
      t = 0;
      while (psum_valid && t < 100) begin
         tick();
         t++;
      end
   endtask

   task automatic checkSeq(input string tag, input int exp[12], input int n);
      checkOutput($sformatf("%s_count", tag), got.size(), n);
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -999999999, exp[i]);
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_filt_ready", filt_ready, 0);
      checkOutput("rst_if_ready", if_ready, 0);
      checkOutput("rst_psum_valid", psum_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_row_done", row_done, 0);
      checkOutput("rst_cfg_err", cfg_err, 0);
      checkOutput("rst_psum_out", psum_out, 0);
      rstn = 1'b1;
      tick();

      // Oversized filter is rejected and the PE stays idle
      configure(0, 13);
      checkOutput("cfgerr_set", cfg_err, 1);
      checkOutput("cfgerr_filt_ready", filt_ready, 0);
      checkOutput("cfgerr_busy", busy, 0);
      tick();
      checkOutput("cfgerr_sticky", cfg_err, 1);

      // Basic row, stride 1
      configure(1, 3);
      checkOutput("cfg_ok_err_cleared", cfg_err, 0);
      checkOutput("load_filt_ready", filt_ready, 1);
      loadFilters(taps_a);
      psum_ready = 1'b1;
      got.delete();
      rb = row_cnt;
      feedRow(row_a, 5);
      waitRows(rb + 1);
      checkSeq("basic", exp_basic, 6);
      checkOutput("basic_row_done", row_cnt - rb, 1);
      checkOutput("basic_busy_fill", busy, 1);

      // Stride 2, element 5 discarded in the flush
      doClear();
      checkOutput("clear_idle_busy", busy, 0);
      configure(2, 3);
      loadFilters(taps_a);
      got.delete();
      rb = row_cnt;
      feedRow(row_a, 5);
      waitRows(rb + 1);
      checkSeq("stride", exp_stride, 4);

      // Backpressure across two rows with the FIFO held full
      doClear();
      configure(1, 3);
      loadFilters(taps_a);
      psum_ready = 1'b0;
      got.delete();
      rb = row_cnt;
      feed_done = 1'b0;
      fork
         begin
            feedRow(row_a, 5);
            feedRow(row_a, 5);
            feed_done = 1'b1;
         end
      join_none
      repeat (200) tick();
      checkOutput("bp_if_stall", if_ready, 0);
      checkOutput("bp_filt_ready", filt_ready, 0);
      checkOutput("bp_no_pop", got.size(), 0);
      checkOutput("bp_psum_valid", psum_valid, 1);
      checkOutput("bp_rows_so_far", row_cnt - rb, 1);
      psum_ready = 1'b1;
      for (int t = 0; t < 3000 && !feed_done; t++) tick();
      checkOutput("bp_feed_done", feed_done, 1);
      waitRows(rb + 2);
      checkSeq("bp", exp_bp, 12);

      // Saturation toward both rails
      doClear();
      configure(1, 3);
      loadFilters(taps_sat);
      got.delete();
      rb = row_cnt;
      feedRow(row_sat, 3);
      waitRows(rb + 1);
      checkSeq("sat", exp_sat, 2);

      // Reset in the middle of a MAC window
      doClear();
      configure(1, 3);
      loadFilters(taps_a);
      got.delete();
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(3, 1'b0);
      tick();
      tick();
      rstn = 1'b0;
      tick();
      checkOutput("mrst_filt_ready", filt_ready, 0);
      checkOutput("mrst_if_ready", if_ready, 0);
      checkOutput("mrst_psum_valid", psum_valid, 0);
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_row_done", row_done, 0);
      checkOutput("mrst_cfg_err", cfg_err, 0);
      checkOutput("mrst_psum_out", psum_out, 0);
      rstn = 1'b1;
      if_in    = DATA_W'(9);
      if_valid = 1'b1;
      repeat (20) tick();
      checkOutput("mrst_if_blocked", if_ready, 0);
      checkOutput("mrst_no_psum", got.size(), 0);
      checkOutput("mrst_psum_valid_after", psum_valid, 0);
      checkOutput("mrst_idle", busy, 0);
      if_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
